// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, payload layout and constants for pipe_stage_buffer
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int PIPE_ILEN = 32;
    localparam int PIPE_SB_W = 4;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_ILEN-1:0] instr;
        logic [PIPE_SB_W-1:0] sb;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - enable-loaded payload register with async reset value
module pipe_payload_reg #(
    parameter int           W         = 68,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - valid/ready pipeline stage register with flush; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter int              ILEN      = PIPE_ILEN,
    parameter int              SB_W      = PIPE_SB_W,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(PIPE_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    input  logic [SB_W-1:0] in_sb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic [SB_W-1:0] out_sb
);

    localparam int PW = XLEN + ILEN + SB_W;

    pipe_state_e   state;
    pipe_state_e   state_nxt;
    logic          in_fire;
    logic          out_fire;
    logic          main_load;
    logic [PW-1:0] in_word;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_word;

    assign in_word   = {in_pc, in_instr, in_sb};
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic          in_ready_q;
    logic          skid_load;
    logic          main_from_skid;
    logic [PW-1:0] skid_word;

    // Registered ready breaks the out_ready -> in_ready path; reset forces it low.
    assign in_ready = in_ready_q & ~rst;
    assign main_d   = main_from_skid ? skid_word : in_word;

    pipe_payload_reg #(
        .W         (PW),
        .RESET_VAL ('0)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_word),
        .q    (skid_word)
    );
`else
    assign in_ready = ~rst & (~out_valid | out_ready);
    assign main_d   = in_word;
`endif

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
`endif
        // Flush wins over any transfer; a beat accepted this cycle is simply dropped.
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_ready) begin
                        main_load = 1'b1;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (in_fire) begin
                        state_nxt = SKID;
                        skid_load = 1'b1;
                    end
`endif
                    else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                SKID: begin
                    if (out_fire) begin
                        state_nxt      = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= (state_nxt != SKID);
`endif
        end
    end

    pipe_payload_reg #(
        .W         (PW),
        .RESET_VAL ({RESET_PC, NOP_INSTR, {SB_W{1'b0}}})
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_word)
    );

    // PC keeps its last value when empty; instruction and sideband read as a bubble.
    assign out_pc    = main_word[PW-1 -: XLEN];
    assign out_instr = out_valid ? main_word[SB_W +: ILEN] : NOP_INSTR;
    assign out_sb    = out_valid ? main_word[SB_W-1:0] : '0;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - self-checking bench for pipe_stage_buffer against a queue model
module tb_pipe_stage_buffer;
    import pipe_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [3:0]  in_sb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [3:0]  out_sb;

    int errors = 0;
    int checks = 0;

    pipe_payload_t q[$];
    logic [31:0]   last_pc;

    always #5 clk = ~clk;

    pipe_stage_buffer #(
        .XLEN      (32),
        .ILEN      (32),
        .SB_W      (4),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_sb     (in_sb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_sb    (out_sb)
    );

    // Capacity is the only difference between the builds as seen from the ports.
    function automatic logic model_in_ready();
        if (rst) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [3:0] sb, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        in_sb     = sb;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        logic          inf;
        logic          outf;
        pipe_payload_t b;
        inf     = in_valid && model_in_ready();
        outf    = (q.size() != 0) && out_ready;
        b.pc    = in_pc;
        b.instr = in_instr;
        b.sb    = in_sb;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(b);
        end
        if (q.size() != 0) last_pc = q[0].pc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        q.delete();
        last_pc = RST_PC;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", out_pc, RST_PC); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", out_instr, NOP); end
        checks++; if (out_sb !== 4'h0) begin errors++; $display("FAIL reset_sb: got %h want 0", out_sb); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_first_beat();
        drive(1'b1, 32'h100, 32'h0050_0093, 4'h5, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL first_pc: got %h want 00000100", out_pc); end
        checks++; if (out_instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h want 00500093", out_instr); end
        checks++; if (out_sb !== 4'h5) begin errors++; $display("FAIL first_sb: got %h want 5", out_sb); end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 4; i++) begin
            drive(i < 4, 32'(4 * i), 32'h0000_0093 | 32'(i << 20), 4'(i), 1'b1, 1'b0);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 1)) ||
                    out_instr !== (32'h0000_0093 | 32'((i - 1) << 20))) begin
                    errors++;
                    $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, 32'(4 * (i - 1)));
                end
            end
            tick();
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 32'h10, 32'h0010_0093, 4'h1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h14, 32'h0020_0093, 4'h2, 1'b0, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000010", out_valid, out_pc); end
`ifdef PIPE_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_skid: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
        tick();
        #1;
        checks++; if (out_pc !== 32'h10 || out_instr !== 32'h0010_0093 || out_sb !== 4'h1) begin errors++; $display("FAIL bp_stable: got pc=%h instr=%h sb=%h want pc=00000010", out_pc, out_instr, out_sb); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_registered_ready: got %b want 0", in_ready); end
        tick();
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
        tick();
        #1;
        checks++; if (out_pc !== 32'h10 || out_instr !== 32'h0010_0093 || out_sb !== 4'h1) begin errors++; $display("FAIL bp_stable: got pc=%h instr=%h sb=%h want pc=00000010", out_pc, out_instr, out_sb); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_comb_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
`endif
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== 32'h0020_0093) begin errors++; $display("FAIL bp_second: got v=%b pc=%h instr=%h want v=1 pc=00000014", out_valid, out_pc, out_instr); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h18, 32'h0030_0093, 4'h3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h1C, 32'h0040_0093, 4'h4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20, 32'h0050_0093, 4'hF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL flush_instr: got %h want %h", out_instr, NOP); end
        checks++; if (out_sb !== 4'h0) begin errors++; $display("FAIL flush_sb: got %h want 0", out_sb); end
        checks++; if (out_pc !== 32'h18) begin errors++; $display("FAIL flush_pc_hold: got %h want 00000018", out_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost[%0d]: got v=%b pc=%h want v=0", i, out_valid, out_pc); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h30, 32'h0060_0093, 4'h6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h34, 32'h0070_0093, 4'h7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL midrst_pc: got %h want %h", out_pc, RST_PC); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL midrst_instr: got %h want %h", out_instr, NOP); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        q.delete();
        last_pc = RST_PC;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h40, 32'h0080_0093, 4'h8, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL midrst_first_out: got v=%b pc=%h want v=1 pc=00000040", out_valid, out_pc); end
        tick();
    endtask

    task automatic test_random();
        int delivered;
        delivered = 0;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            #1;
            checks++; if (in_ready !== model_in_ready()) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, model_in_ready()); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, q.size() != 0); end
            checks++;
            if (q.size() != 0) begin
                if (out_pc !== q[0].pc || out_instr !== q[0].instr || out_sb !== q[0].sb) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h/%h/%h want %h/%h/%h", n, out_pc, out_instr, out_sb, q[0].pc, q[0].instr, q[0].sb);
                end
                if (out_ready) delivered++;
            end else if (out_pc !== last_pc || out_instr !== NOP || out_sb !== 4'h0) begin
                errors++;
                $display("FAIL rand_empty[%0d]: got %h/%h/%h want %h/%h/0", n, out_pc, out_instr, out_sb, last_pc, NOP);
            end
            tick();
        end
        checks++; if (delivered < 100) begin errors++; $display("FAIL rand_throughput: got %0d beats want >= 100", delivered); end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_stream();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised pipeline stage register with a valid/ready handshake, flush and an optional skid entry. It is the successor to the fixed fetch-to-decode PC latch. It carries PC, instruction word and a generic sideband field between any two pipeline stages (IF/ID, ID/EX, ...). Stall comes from downstream back-pressure. Flush comes from branch/jump resolution and inserts a bubble.

Parameters:
XLEN, 32, PC width in bits
ILEN, 32, instruction word width in bits
SB_W, 4, sideband width (e.g. predicted-taken, exception flags); must be >= 1
RESET_PC, 32'h0000_0000, value of out_pc after reset
NOP_INSTR, 32'h0000_0013, instruction driven on out_instr when stage is empty (addi x0,x0,0)

Ports:
clk        in   1      clock, all state on rising edge
rst        in   1      reset, asynchronous, active-high
flush      in   1      synchronous kill of all held entries and of the current input beat
in_valid   in   1      upstream beat valid
in_ready   out  1      stage can accept a beat this cycle
in_pc      in   XLEN   upstream PC
in_instr   in   ILEN   upstream instruction
in_sb      in   SB_W   upstream sideband
out_valid  out  1      downstream beat valid
out_ready  in   1      downstream accepts
out_pc     out  XLEN   held PC
out_instr  out  ILEN   held instruction; NOP_INSTR when empty
out_sb     out  SB_W   held sideband; 0 when empty

Behaviour:
- Transfers: in fires when in_valid & in_ready; out fires when out_valid & out_ready. All state updates on posedge clk.
- Reset (async, any cycle, including mid-transfer):
  - out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR, out_sb=0.
  - Skid entry cleared; in_ready=0 while rst high, 1 in the first cycle after release.
- Latency: exactly 1 cycle from input fire to out_valid. Throughput 1 beat/cycle.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- States (skid build): EMPTY, FULL (main entry valid), SKID (main + skid valid).
  - EMPTY: in fire -> FULL.
  - FULL:
    - in fire & out fire -> FULL (main reloads from input).
    - in fire & !out_ready -> SKID (input stored in skid entry).
    - out fire only -> EMPTY.
  - SKID: out fire -> FULL (skid moves to main); otherwise hold.
- in_ready is a registered signal, = (state != SKID); no combinational path from out_ready to in_ready.
- Output data registers load only on a state transition that brings in a new beat. When empty, outputs are NOP_INSTR / sb=0 and out_pc holds its last value.
- flush=1 in any state: next state EMPTY, out_valid=0, out_instr=NOP_INSTR, out_sb=0.
  - An input beat presented in the same cycle is consumed (in_ready unaffected) and discarded.
  - flush has priority over simultaneous in fire and out fire. An out fire in the flush cycle still completes downstream.
- Output stability: while out_valid=1 and out_ready=0, out_pc/out_instr/out_sb must not change.
- PC arithmetic: none. Widths pass through unchanged.

Optional Feature:
Macro PIPE_STAGE_SKID_EN.
- Defined: 2-entry skid behaviour as above; in_ready registered.
- Undefined: single entry only, no SKID state, in_ready = !out_valid | out_ready (combinational). Latency, flush and reset behaviour are identical; area roughly halved.

Decomposition:
- Package pipe_pkg: state enum pipe_state_e {EMPTY, FULL, SKID}, default NOP_INSTR constant, packed struct pipe_payload_t {pc, instr, sb} sized from package-level XLEN/ILEN/SB_W defaults.
- One natural sub-module, pipe_payload_reg: enable-loaded payload register with async reset value, instantiated for main and skid entries.

Test Plan:
- Reset release, in_valid=1, in_pc=0x100, in_instr=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093.
- Stream pc=0x0,0x4,0x8,0xC with out_ready=1 -> 1 beat/cycle, order preserved, in_ready stays 1.
- Back-pressure: out_ready=0 after beat 0x10 while 0x14 arrives -> in_ready drops to 0, out holds 0x10 stable. Raise out_ready -> 0x10 then 0x14, no loss.
- flush=1 in SKID state with in_valid=1 pc=0x20 -> next cycle out_valid=0, out_instr=0x00000013, out_sb=0; 0x20 never appears.
- Assert rst mid-SKID -> immediately out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR; after release the first accepted beat is the first output.
- Build without PIPE_STAGE_SKID_EN, repeat the back-pressure case -> in_ready follows out_ready combinationally in the same cycle, data correct.
